vga_timing_driver: RTL and testbench



---
 rtl/vga_timing_driver.sv | 129 ++++++++++++
 tb/tb_vga_timing_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: 640x480@60 VGA timing from the 25 MHz pixel clock, with blanked, registered color.
// Optional build macro VGA_TEST_PATTERN_EN replaces the color input with eight vertical color bars.
module vga_timing_driver #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  output logic [11:0] x,
  output logic [11:0] y,
  input  logic [2:0]  color,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
  localparam logic [11:0] HS_START  = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END    = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_VIS_END = 12'(V_VISIBLE);
  localparam logic [11:0] VS_START  = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END    = 12'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_VISIBLE / 8);

  function automatic logic [2:0] bar_index(input logic [11:0] h);
    logic [11:0] q;
    q = h / BAR_W;
    return q[2:0];
  endfunction
`endif

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;
  logic        vis, hs_raw, vs_raw;
  logic [2:0]  pix_src;
  logic [2:0]  rgb_q, rgb_d;
  logic        active_q, active_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  // Stage 0: raster counters; x/y are their unregistered copies
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign x = h_cnt_q;
  assign y = v_cnt_q;

  always_comb begin
    vis    = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    hs_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
`ifdef VGA_TEST_PATTERN_EN
    pix_src = bar_index(h_cnt_q);
`else
    pix_src = color;
`endif
  end

  // Stage 1: everything derived from the same count is registered together so the pins stay aligned;
  // the explicit mux keeps an unknown color from leaking into blanking.
  always_comb begin
    rgb_d         = vis ? pix_src : 3'b000;
    active_d      = vis;
    hsync_d       = hs_raw ? SYNC_POL : ~SYNC_POL;
    vsync_d       = vs_raw ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q         <= 3'b000;
      active_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_R       = rgb_q[2];
  assign VGA_G       = rgb_q[1];
  assign VGA_B       = rgb_q[0];
  assign active      = active_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver: full horizontal timing, vertical totals shortened
// (4/2/2/3 lines, 11-line frame of 8800 clocks) so several frames fit in a short run.
module tb_vga_timing_driver;

  localparam int HT = 800;
  localparam int VV = 4;
  localparam int VT = 11;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] x, y;
  logic [2:0]  color, color_drv;
  logic        blank_junk = 1'b0;
  logic        vga_r, vga_g, vga_b, hsync, vsync, active, frame_start;
  int          errors = 0;
  int          checks = 0;

  // Outside the visible area the generator may drive anything; a non-zero value exposes leaks.
  assign color = (blank_junk && !(x < 12'd640 && y < 12'(VV))) ? 3'b010 : color_drv;

  always #20 clk = ~clk;

  vga_timing_driver #(
    .V_VISIBLE(VV), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x), .y(y), .color(color),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .HSYNC(hsync), .VSYNC(vsync),
    .active(active), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rgb(input int px, input int py);
    if (!(px < 640 && py < VV)) return 3'b000;
`ifdef VGA_TEST_PATTERN_EN
    return 3'(px / 80);
`else
    return 3'b101;
`endif
  endfunction

  initial begin
    int p, px, py, q, xe, ye, hs_e, vs_e, vis_e, fs_e;
    int mism, first_hs, last_hs, hs_cnt0, act0, first_vs, vs_cnt, act_f, fs_cnt;
    int fs_k[4];
    logic [2:0] rgb640, rgb641;
    logic act641;
    logic [11:0] x800, y800, xw, yw;

    mism = 0; first_hs = -1; last_hs = -1; hs_cnt0 = 0; act0 = 0;
    first_vs = -1; vs_cnt = 0; act_f = 0; fs_cnt = 0;
    fs_k = '{default: 0};
    rgb640 = 3'b000; rgb641 = 3'b111; act641 = 1'b1;
    x800 = '1; y800 = '1; xw = '1; yw = '1;

    // Reset held with a bright color on the input
    color_drv = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_fs", 32'(frame_start), 0);

    // Release; k counts rising edges since release
    color_drv = 3'b101;
    rst_n = 1'b1;
    chk("rel_x", 32'(x), 0);
    chk("rel_fs", 32'(frame_start), 0);

    for (int k = 1; k <= 2 * FT + 1; k++) begin
      @(negedge clk);
      p  = (k - 1) % FT; px = p % HT; py = p / HT;
      q  = k % FT;       xe = q % HT; ye = q / HT;
      vis_e = (px < 640 && py < VV) ? 1 : 0;
      hs_e  = (px >= 656 && px < 752) ? 0 : 1;
      vs_e  = (py >= 6 && py < 8) ? 0 : 1;
      fs_e  = (p == 0) ? 1 : 0;
      if (x !== 12'(xe) || y !== 12'(ye) || {vga_r, vga_g, vga_b} !== exp_rgb(px, py) ||
          active !== 1'(vis_e) || hsync !== 1'(hs_e) || vsync !== 1'(vs_e) ||
          frame_start !== 1'(fs_e))
        mism++;
      if (k <= HT && !hsync) begin
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        hs_cnt0++;
      end
      if (k <= HT && active) act0++;
      if (k <= FT && !vsync) begin
        if (first_vs < 0) first_vs = k;
        vs_cnt++;
      end
      if (k <= FT && active) act_f++;
      if (frame_start) begin
        if (fs_cnt < 4) fs_k[fs_cnt] = k;
        fs_cnt++;
      end
      if (k == 640) rgb640 = {vga_r, vga_g, vga_b};
      if (k == 641) begin rgb641 = {vga_r, vga_g, vga_b}; act641 = active; end
      if (k == HT) begin x800 = x; y800 = y; end
      if (k == FT) begin xw = x; yw = y; blank_junk = 1'b1; end
    end

    chk("hs_first", 32'(first_hs), 657);
    chk("hs_last", 32'(last_hs), 752);
    chk("hs_width", 32'(hs_cnt0), 96);
    chk("act_line", 32'(act0), 640);
    chk("vs_first", 32'(first_vs), 6 * HT + 1);
    chk("vs_width", 32'(vs_cnt), 1600);
    chk("act_frame", 32'(act_f), 640 * VV);
    chk("fs_count", 32'(fs_cnt), 3);
    chk("fs_first", 32'(fs_k[0]), 1);
    chk("fs_period1", 32'(fs_k[1] - fs_k[0]), FT);
    chk("fs_period2", 32'(fs_k[2] - fs_k[1]), FT);
    chk("rgb_px639", 32'(rgb640), 32'(exp_rgb(639, 0)));
    chk("rgb_px640", 32'(rgb641), 0);
    chk("act_px640", 32'(act641), 0);
    chk("line_wrap_x", 32'(x800), 0);
    chk("line_wrap_y", 32'(y800), 1);
    chk("frame_wrap_x", 32'(xw), 0);
    chk("frame_wrap_y", 32'(yw), 0);
    chk("cycle_mismatches", 32'(mism), 0);

    // Mid-frame reset between clock edges
    for (int n = 0; n < 20000 && !(x == 12'd300 && y == 12'd2); n++) @(negedge clk);
    chk("mid_x", 32'(x), 300);
    chk("mid_y", 32'(y), 2);
    chk("mid_active_before", 32'(active), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 0);
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_vsync", 32'(vsync), 1);
    chk("mid_rst_fs", 32'(frame_start), 0);
    @(negedge clk);
    chk("mid_hold_x", 32'(x), 0);
    rst_n = 1'b1;
    chk("mid_rel_fs", 32'(frame_start), 0);
    @(negedge clk);
    chk("mid_restart_x", 32'(x), 1);
    chk("mid_restart_y", 32'(y), 0);
    chk("mid_restart_fs", 32'(frame_start), 1);
    chk("mid_restart_active", 32'(active), 1);
    chk("mid_restart_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(0, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
